// File: rtl/aes_pkg.sv
// Shared AES datapath definitions.
//   - State, column and byte geometry of the 128-bit AES state.
//   - FSM state encoding used by the ShiftRows column serializer.
//   - get_col(): extracts column c of a column-major state word
//     (column 0 occupies the most significant 32 bits).
package aes_pkg;

  localparam int STATE_W  = 128;  // full AES state
  localparam int COL_W    = 32;   // one state column (4 bytes)
  localparam int BYTE_W   = 8;
  localparam int BYTE_CNT = 16;   // bytes per state
  localparam int COL_CNT  = 4;    // columns (and rows) per state
  localparam int IDX_W    = 2;    // width of a column index

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // Column c of a column-major state: bytes 4c..4c+3, row 0 highest.
  function automatic logic [COL_W-1:0] get_col(
    input logic [STATE_W-1:0] state,
    input logic [IDX_W-1:0]   c
  );
    get_col = state[STATE_W-1-COL_W*int'(c) -: COL_W];
  endfunction

endpackage

// File: rtl/shift_rows.sv
// AES ShiftRows, purely combinational.
//   state   : 128-bit state, column-major, byte k at [127-8k -: 8],
//             byte k = s[r][c] with k = 4c + r.
//   shifted : same layout after ShiftRows; row r is rotated left by r,
//             i.e. shifted s'[r][c] = s[r][(c+r) % 4].
module shift_rows
  import aes_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  output logic [STATE_W-1:0] shifted
);

  // Each destination byte is a fixed wire from one source byte; the
  // generate loop just spells out the permutation.
  for (genvar gi = 0; gi < BYTE_CNT; gi++) begin : g_byte
    localparam int ROW = gi % COL_CNT;
    localparam int COL = gi / COL_CNT;
    localparam int SRC = COL_CNT * ((COL + ROW) % COL_CNT) + ROW;

    assign shifted[STATE_W-1-BYTE_W*gi -: BYTE_W] =
           state[STATE_W-1-BYTE_W*SRC -: BYTE_W];
  end

endmodule

// File: rtl/shift_rows_serializer.sv
// ShiftRows stage that hands the shifted state to MixColumns one column
// per cycle over a valid/ready pair.
//   CLK, RST     : clock and synchronous active-high reset
//   din          : 128-bit state after SubBytes, column-major
//   din_vld/rdy  : input handshake (block taken when both high)
//   last_in      : final-round flag, captured with din
//   col_out      : shifted column, row 0 in [31:24]
//   col_vld/rdy  : output handshake (column taken when both high)
//   col_idx      : index 0..3 of col_out
//   col_end      : marks column 3
//   last_out     : captured last_in, constant across the block's columns
// ACCEPT_EARLY=1 lets the next block load in the same cycle column 3 is
// consumed, giving one column per cycle with no bubble between blocks.
module shift_rows_serializer
  import aes_pkg::*;
#(
  parameter bit ACCEPT_EARLY = 1'b1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [STATE_W-1:0] din,
  input  logic               din_vld,
  output logic               din_rdy,
  input  logic               last_in,
  output logic [COL_W-1:0]   col_out,
  output logic               col_vld,
  input  logic               col_rdy,
  output logic [IDX_W-1:0]   col_idx,
  output logic               col_end,
  output logic               last_out
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COL_CNT - 1);

  ser_state_t         state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [STATE_W-1:0] data_reg;
  logic               last_reg;

  logic [STATE_W-1:0] shifted;
  logic               sending;
  logic               at_last;

  shift_rows u_shift_rows (
    .state   (din),
    .shifted (shifted)
  );

  assign sending = (state_reg == SEND);
  assign at_last = (idx_reg == LAST_IDX);

  // The ShiftRows permutation is applied once at load so the stored word
  // already holds output columns; the per-cycle mux is then a plain
  // column select.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (din_vld) begin
            data_reg  <= shifted;
            last_reg  <= last_in;
            idx_reg   <= '0;
            state_reg <= SEND;
          end
        end
        SEND: begin
          if (col_rdy) begin
            if (!at_last) begin
              idx_reg <= idx_reg + 1'b1;
            end else if (ACCEPT_EARLY && din_vld) begin
              // Overlap: last column leaves as the next block arrives.
              data_reg <= shifted;
              last_reg <= last_in;
              idx_reg  <= '0;
            end else begin
              idx_reg   <= '0;
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          idx_reg   <= '0;
        end
      endcase
    end
  end

  // Outputs decode directly from registers so they stay stable while
  // col_rdy is low; only din_rdy looks at inputs (col_rdy, and RST so no
  // block is accepted while reset is held).
  assign col_vld  = sending;
  assign col_out  = sending ? get_col(data_reg, idx_reg) : '0;
  assign col_idx  = sending ? idx_reg : '0;
  assign col_end  = sending & at_last;
  assign last_out = sending & last_reg;
  assign din_rdy  = ~RST & (~sending | (ACCEPT_EARLY & at_last & col_rdy));

endmodule

// File: tb/tb_shift_rows_serializer.sv
module tb_shift_rows_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] din;
  logic         last_in;

  // Instance "a": ACCEPT_EARLY=1, instance "b": ACCEPT_EARLY=0.
  logic         a_din_vld, a_din_rdy, a_col_vld, a_col_rdy, a_col_end, a_last_out;
  logic [31:0]  a_col_out;
  logic [1:0]   a_col_idx;
  logic         b_din_vld, b_din_rdy, b_col_vld, b_col_rdy, b_col_end, b_last_out;
  logic [31:0]  b_col_out;
  logic [1:0]   b_col_idx;

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] VEC_A = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] VEC_B = 128'h000102030405060708090a0b0c0d0e0f;

  logic [31:0] cols_a [4];
  logic [31:0] cols_b [4];

  always #5 clk = ~clk;

  shift_rows_serializer #(.ACCEPT_EARLY(1'b1)) dut_a (
    .CLK(clk), .RST(rst), .din(din), .din_vld(a_din_vld), .din_rdy(a_din_rdy),
    .last_in(last_in), .col_out(a_col_out), .col_vld(a_col_vld),
    .col_rdy(a_col_rdy), .col_idx(a_col_idx), .col_end(a_col_end),
    .last_out(a_last_out)
  );

  shift_rows_serializer #(.ACCEPT_EARLY(1'b0)) dut_b (
    .CLK(clk), .RST(rst), .din(din), .din_vld(b_din_vld), .din_rdy(b_din_rdy),
    .last_in(last_in), .col_out(b_col_out), .col_vld(b_col_vld),
    .col_rdy(b_col_rdy), .col_idx(b_col_idx), .col_end(b_col_end),
    .last_out(b_last_out)
  );

  function automatic logic [7:0] xtime(input logic [7:0] v);
    xtime = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // Row 0 of MixColumns: 2*a0 ^ 3*a1 ^ a2 ^ a3.
  function automatic logic [7:0] mix_row0(input logic [31:0] c);
    mix_row0 = xtime(c[31:24]) ^ xtime(c[23:16]) ^ c[23:16] ^ c[15:8] ^ c[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic col_a(input int c, input logic [31:0] exp, input logic last, input logic rdy);
    $display("[TB] a col idx=%0d data=%h last=%0b", a_col_idx, a_col_out, a_last_out);
    chk("a_col_vld", 32'(a_col_vld), 32'd1);
    chk("a_col_out", a_col_out, exp);
    chk("a_col_idx", 32'(a_col_idx), 32'(c));
    chk("a_col_end", 32'(a_col_end), 32'(c == 3));
    chk("a_last_out", 32'(a_last_out), 32'(last));
    chk("a_din_rdy", 32'(a_din_rdy), 32'(rdy));
  endtask

  task automatic col_b(input int c, input logic [31:0] exp, input logic last);
    $display("[TB] b col idx=%0d data=%h last=%0b", b_col_idx, b_col_out, b_last_out);
    chk("b_col_vld", 32'(b_col_vld), 32'd1);
    chk("b_col_out", b_col_out, exp);
    chk("b_col_idx", 32'(b_col_idx), 32'(c));
    chk("b_col_end", 32'(b_col_end), 32'(c == 3));
    chk("b_last_out", 32'(b_last_out), 32'(last));
    chk("b_din_rdy", 32'(b_din_rdy), 32'd0);
  endtask

  task automatic idle_a(input string tag);
    $display("[TB] a idle (%s)", tag);
    chk({tag, "_a_col_vld"}, 32'(a_col_vld), 32'd0);
    chk({tag, "_a_col_out"}, a_col_out, 32'd0);
    chk({tag, "_a_col_idx"}, 32'(a_col_idx), 32'd0);
    chk({tag, "_a_col_end"}, 32'(a_col_end), 32'd0);
    chk({tag, "_a_last_out"}, 32'(a_last_out), 32'd0);
    chk({tag, "_a_din_rdy"}, 32'(a_din_rdy), 32'd1);
  endtask

  initial begin
    // Hand-derived ShiftRows columns of the two vectors.
    cols_a[0] = 32'hd4bf5d30; cols_a[1] = 32'he0b452ae;
    cols_a[2] = 32'hb84111f1; cols_a[3] = 32'h1e2798e5;
    cols_b[0] = 32'h00050a0f; cols_b[1] = 32'h04090e03;
    cols_b[2] = 32'h080d0207; cols_b[3] = 32'h0c01060b;

    rst = 1'b1; din = '0; last_in = 1'b0;
    a_din_vld = 1'b0; a_col_rdy = 1'b0;
    b_din_vld = 1'b0; b_col_rdy = 1'b1;

    // Reset held: nothing accepted, outputs cleared.
    tick; tick;
    @(negedge clk);
    chk("rst_a_din_rdy", 32'(a_din_rdy), 32'd0);
    chk("rst_b_din_rdy", 32'(b_din_rdy), 32'd0);
    chk("rst_a_col_vld", 32'(a_col_vld), 32'd0);
    chk("rst_a_col_out", a_col_out, 32'd0);
    tick;
    rst = 1'b0;
    @(negedge clk);
    idle_a("post_rst");
    chk("post_rst_b_din_rdy", 32'(b_din_rdy), 32'd1);
    tick;

    // Single block, col_rdy always high.
    din = VEC_A; a_din_vld = 1'b1; a_col_rdy = 1'b1;
    @(negedge clk);
    chk("t1_accept_rdy", 32'(a_din_rdy), 32'd1);
    tick;
    a_din_vld = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      col_a(c, cols_a[c], 1'b0, c == 3);
      if (c == 0) chk("t1_mix_col0_row0", 32'(mix_row0(a_col_out)), 32'h04);
      tick;
    end
    @(negedge clk);
    idle_a("t1_end");
    tick;

    // Backpressure during column 1.
    din = VEC_A; a_din_vld = 1'b1; a_col_rdy = 1'b0;
    tick;
    a_din_vld = 1'b0; a_col_rdy = 1'b1;
    @(negedge clk);
    col_a(0, cols_a[0], 1'b0, 1'b0);
    tick;
    a_col_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      col_a(1, cols_a[1], 1'b0, 1'b0);
      tick;
    end
    a_col_rdy = 1'b1;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      col_a(c, cols_a[c], 1'b0, c == 3);
      tick;
    end
    @(negedge clk);
    idle_a("t2_end");
    tick;

    // ACCEPT_EARLY=1: two blocks back-to-back, second is a final round.
    din = VEC_A; last_in = 1'b0; a_din_vld = 1'b1; a_col_rdy = 1'b1;
    tick;
    din = VEC_B; last_in = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      col_a(c, cols_a[c], 1'b0, c == 3);
      tick;
    end
    a_din_vld = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      col_a(c, cols_b[c], 1'b1, c == 3);
      tick;
    end
    @(negedge clk);
    idle_a("t3_end");
    tick;

    // ACCEPT_EARLY=0: same stimulus, one IDLE bubble between blocks.
    din = VEC_A; last_in = 1'b0; b_din_vld = 1'b1; b_col_rdy = 1'b1;
    tick;
    din = VEC_B; last_in = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      col_b(c, cols_a[c], 1'b0);
      tick;
    end
    @(negedge clk);
    $display("[TB] b bubble");
    chk("t4_bubble_col_vld", 32'(b_col_vld), 32'd0);
    chk("t4_bubble_col_out", b_col_out, 32'd0);
    chk("t4_bubble_din_rdy", 32'(b_din_rdy), 32'd1);
    tick;
    b_din_vld = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      col_b(c, cols_b[c], 1'b1);
      tick;
    end
    @(negedge clk);
    chk("t4_end_col_vld", 32'(b_col_vld), 32'd0);
    chk("t4_end_din_rdy", 32'(b_din_rdy), 32'd1);
    tick;

    // Reset pulse at idx 2 wins over din_vld/col_rdy; new block restarts.
    din = VEC_A; last_in = 1'b0; a_din_vld = 1'b1; a_col_rdy = 1'b1;
    tick;
    a_din_vld = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      col_a(c, cols_a[c], 1'b0, 1'b0);
      tick;
    end
    din = VEC_B; last_in = 1'b1; a_din_vld = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("t5_pre_rst_idx", 32'(a_col_idx), 32'd2);
    chk("t5_rst_din_rdy", 32'(a_din_rdy), 32'd0);
    tick;
    rst = 1'b0;
    @(negedge clk);
    idle_a("t5_after_rst");
    tick;
    a_din_vld = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      col_a(c, cols_b[c], 1'b1, c == 3);
      tick;
    end
    @(negedge clk);
    idle_a("t5_end");
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
